sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
- Parametrised N-input, WIDTH-bit operand selector with a registered output stage and a valid/ready handshake.
- Successor to the fixed 32-bit 4:1 combinational selector in the datapath. Used for forwarding and operand selection where the select must be registered and the stage must absorb downstream stalls without dropping data.
- A 2-entry skid buffer decouples in_ready from out_ready. Pipeline flush is supported.

Parameters:
- WIDTH, 32, data width of each input lane and of the output.
- NUM_IN, 4, number of input lanes (≥2; need not be a power of two).
- SEL_W, $clog2(NUM_IN), select width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush; discards all held beats
- in_data  in  NUM_IN*WIDTH  packed lanes; lane k = in_data[k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  binary lane select
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- out_data  out  WIDTH  selected lane, registered
- out_err  out  1  beat was produced from an out-of-range select
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat

Behaviour:
- Accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Selection is done at accept time. If in_sel ≥ NUM_IN, lane 0 is captured and out_err=1 travels with that beat; otherwise out_err=0.
- Storage: main register (drives out_*) and skid register, each holding {data, err} plus a valid bit.
- in_ready = ~skid_valid. It is a register-derived signal with no combinational path from out_ready.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- Transitions:
  - EMPTY: accept -> ONE, main <= beat.
  - ONE: accept & transfer -> ONE, main <= beat.
  - ONE: accept & ~transfer -> FULL, skid <= beat.
  - ONE: ~accept & transfer -> EMPTY.
  - ONE: neither -> hold.
  - FULL: in_ready=0. Transfer -> ONE, main <= skid. Otherwise hold.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1 when the stage was EMPTY, or when it was ONE with a transfer in t.
- Stall: while out_valid & ~out_ready, out_data and out_err are held stable.
- Ordering is strictly FIFO. No beat is ever dropped except by rst or flush.
- Priority: rst > flush > normal operation.
  - rst: next state EMPTY; out_valid=0, out_data=0, out_err=0, skid cleared, in_ready=1 from the first cycle after reset. Beats presented while rst=1 are ignored.
  - flush: next state EMPTY from any state. A beat accepted in the flush cycle is discarded, and a transfer in that cycle still counts as completed for the consumer. out_data and out_err keep their last value but out_valid=0.
- Reset or flush arriving mid-stall (FULL): both entries are discarded and no partial beat is emitted.
- Data paths are pure selection: no arithmetic, no width change.

Decomposition:
- Shared package: sel_mux_pkg.
  - Localparam state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Helper function for the lane-index range check.
- Sub-module: sel_mux_comb, a purely combinational parametrised NUM_IN:1 selector producing {data, err}.
  - Instantiated once on the input side of the stage.
  - Also reusable standalone elsewhere in the datapath.

Test Plan:
- Reset/basic: rst for 2 cycles, then NUM_IN=4, lanes {0x11,0x22,0x33,0x44}, in_sel=2, in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 next cycle with out_data=0x33 and out_err=0; out_valid=0 the following cycle.
- Streaming: sel sequence 0,1,2,3 on back-to-back cycles with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0, send sel=1 then sel=3 -> in_ready drops to 0 after the second accept and out_data holds 0x22. Raise out_ready -> 0x22 then 0x44 are delivered in order; in_ready returns to 1.
- Out-of-range: NUM_IN=3, lanes {0xA,0xB,0xC}, in_sel=3 -> out_data=0xA and out_err=1. Next beat with in_sel=2 -> out_data=0xC and out_err=0.
- Flush mid-stall: reach FULL with out_ready=0, assert flush for 1 cycle with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; neither held beat nor the flush-cycle beat ever appears.
- Reset priority: rst and flush asserted together while in ONE, with in_valid=1 -> out_valid=0 and out_data=0 next cycle; no beat accepted.

Source files
------------

// File: rtl/sel_mux_pkg.sv
// Shared definitions for the registered operand selector: stage state
// encodings and the lane-index range check used by the selector.
package sel_mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic lane_in_range(input int unsigned sel, input int unsigned num_in);
    return (sel < num_in);
  endfunction

endpackage

// File: rtl/sel_mux_comb.sv
// Purely combinational NUM_IN:1 lane selector. An out-of-range select
// returns lane 0 and raises err so the caller can flag the beat.
module sel_mux_comb
  import sel_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  always_comb begin
    out_data = in_data[0 +: WIDTH];
    out_err  = !lane_in_range(32'(in_sel), NUM_IN);
    for (int k = 1; k < NUM_IN; k++) begin
      if (32'(in_sel) == k) out_data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered operand selector with valid/ready handshake and a 2-entry skid
// buffer so in_ready never depends combinationally on out_ready.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              dbg_state
);

  // Handshake: a beat moves when valid & ready are both high on a rising
  // edge; valid is never withdrawn by this stage until the beat transfers
  // (except by rst/flush), and held data stays stable while stalled.

  state_e            r_state, w_state_next;
  logic [WIDTH-1:0]  r_main_data, r_skid_data, w_sel_data;
  logic              r_main_err, r_skid_err, w_sel_err;
  logic              w_accept, w_transfer;
  logic              w_load_main_in, w_load_main_skid, w_load_skid;

  sel_mux_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_sel (
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_data (w_sel_data),
    .out_err  (w_sel_err)
  );

  // Entry valid bits are the state itself: main valid unless EMPTY, skid valid only in FULL.
  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main_data;
  assign out_err    = r_main_err;
  assign dbg_state  = r_state;
  assign w_accept   = in_valid & in_ready;
  assign w_transfer = out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next   = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_transfer) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_FULL;
          w_load_skid  = 1'b1;
        end else if (w_transfer) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_transfer) begin
          w_state_next     = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    // Flush drops every held beat but leaves the output data visible (invalid).
    if (flush) begin
      w_state_next     = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_main_in) begin
        r_main_data <= w_sel_data;
        r_main_err  <= w_sel_err;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_err  <= w_sel_err;
      end
    end
  end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: a 4-lane and a 3-lane instance share the handshake
// controls and are checked every cycle against a queue-based reference model.
module tb_sel_mux_pipe;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, flush, in_valid, out_ready;
  logic [1:0]     in_sel;
  logic [4*W-1:0] in_data4;
  logic [3*W-1:0] in_data3;

  logic           in_ready4, out_err4, out_valid4;
  logic [W-1:0]   out_data4;
  logic [1:0]     dbg_state4;
  logic           in_ready3, out_err3, out_valid3;
  logic [W-1:0]   out_data3;
  logic [1:0]     dbg_state3;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {err, data} beats held in the stage, oldest first.
  logic [W:0] exp_q4[$];
  logic [W:0] exp_q3[$];
  logic [W:0] last4, last3;

  sel_mux_pipe #(.WIDTH(W), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data4), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4), .out_err(out_err4),
    .out_valid(out_valid4), .out_ready(out_ready), .dbg_state(dbg_state4)
  );

  sel_mux_pipe #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data3), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready), .dbg_state(dbg_state3)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W:0] pick4(input logic [4*W-1:0] d, input logic [1:0] s);
    return {1'b0, d[int'(s)*W +: W]};
  endfunction

  function automatic logic [W:0] pick3(input logic [3*W-1:0] d, input logic [1:0] s);
    if (int'(s) >= 3) return {1'b1, d[0 +: W]};
    return {1'b0, d[int'(s)*W +: W]};
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: one rising edge applied to the queues.
  task automatic model_edge();
    int  occ;
    logic can_take;
    occ = exp_q4.size();
    if (rst) begin
      exp_q4.delete();
      exp_q3.delete();
      last4 = '0;
      last3 = '0;
    end else if (flush) begin
      exp_q4.delete();
      exp_q3.delete();
    end else begin
      can_take = (occ < 2);
      if (occ > 0 && out_ready) begin
        void'(exp_q4.pop_front());
        void'(exp_q3.pop_front());
      end
      if (in_valid && can_take) begin
        exp_q4.push_back(pick4(in_data4, in_sel));
        exp_q3.push_back(pick3(in_data3, in_sel));
      end
    end
    if (exp_q4.size() > 0) begin
      last4 = exp_q4[0];
      last3 = exp_q3[0];
    end
  endtask

  task automatic compare();
    int occ;
    occ = exp_q4.size();
    check("out_valid4", W'(out_valid4), W'(occ > 0));
    check("in_ready4",  W'(in_ready4),  W'(occ < 2));
    check("state4",     W'(dbg_state4), W'(occ));
    check("beat4",      {out_err4, out_data4}, last4);
    check("out_valid3", W'(out_valid3), W'(occ > 0));
    check("in_ready3",  W'(in_ready3),  W'(occ < 2));
    check("state3",     W'(dbg_state3), W'(occ));
    check("beat3",      {out_err3, out_data3}, last3);
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [1:0] s, input logic ordy,
                       input logic fl, input logic rs);
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    in_data4 = {32'h44, 32'h33, 32'h22, 32'h11};
    in_data3 = {32'hC, 32'hB, 32'hA};
    last4 = '0;
    last3 = '0;

    // Reset for 2 cycles with a beat presented (must be ignored)
    drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
    cycle();
    cycle();
    check("reset_data", W'(out_data4), W'(0));

    // Basic: sel=2 for one cycle
    drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cycle();
    check("basic_valid", W'(out_valid4), W'(1));
    check("basic_data",  {out_err4, out_data4}, {1'b0, 32'h33});
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("basic_gone", W'(out_valid4), W'(0));

    // Streaming 0..3 back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b1, 1'b0, 1'b0);
      cycle();
      check("stream_data", W'(out_data4), W'(32'h11 * (i + 1)));
      check("stream_ready", W'(in_ready4), W'(1));
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Backpressure: fill to FULL, hold, then drain in order
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cycle();
    check("bp_ready_low", W'(in_ready4), W'(0));
    check("bp_hold", W'(out_data4), W'(32'h22));
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("bp_hold2", W'(out_data4), W'(32'h22));
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("bp_second", W'(out_data4), W'(32'h44));
    check("bp_ready_back", W'(in_ready4), W'(1));
    cycle();

    // Out-of-range select on the 3-lane instance
    drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    cycle();
    check("oor_beat", {out_err3, out_data3}, {1'b1, 32'hA});
    drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cycle();
    check("inrange_beat", {out_err3, out_data3}, {1'b0, 32'hC});
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Flush mid-stall, then flush with an accept in ONE
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    cycle();
    check("flush_valid", W'(out_valid4), W'(0));
    check("flush_ready", W'(in_ready4), W'(1));
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();

    // Reset beats flush while in ONE
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
    cycle();
    check("rstprio_valid", W'(out_valid4), W'(0));
    check("rstprio_data",  {out_err3, out_data3}, '0);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) in_data4[k*W +: W] = $urandom;
      for (int k = 0; k < 3; k++) in_data3[k*W +: W] = $urandom;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 149) == 0);
      cycle();
    end

    // Drain
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    check("drained", W'(out_valid4), W'(0));

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
